// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: bus widths, opcode encodings,
// the control FSM state type and a small opcode classification helper.
package cpu_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI   = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h3;
  localparam logic [OP_W-1:0] OP_AND   = 4'h4;
  localparam logic [OP_W-1:0] OP_OR    = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h7;
  localparam logic [OP_W-1:0] OP_STORE = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP   = 4'h9;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'hA;
  localparam logic [OP_W-1:0] OP_JZ    = 4'hB;
  localparam logic [OP_W-1:0] OP_JN    = 4'hC;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_STORE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // True for opcodes whose only effect is a new accumulator value from the ALU.
  function automatic logic is_acc_op(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_NOT, OP_XOR, OP_LOAD: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU.
// Ports:
//   opcode  - IR[15:12] of the executing instruction
//   acc     - current accumulator
//   operand - memory word M at IR[11:0]
//   imm     - IR[11:0], used as the zero-extended LDI immediate
//   result  - next accumulator value for LDI..XOR and LOAD; ACC otherwise
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [ADDR_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] result_s;

  // Select the accumulator update for the current opcode; arithmetic wraps mod 2^16.
  always_comb begin
    result_s = acc;
    case (opcode)
      OP_LDI:  result_s = {{(DATA_W-ADDR_W){1'b0}}, imm};
      OP_ADD:  result_s = acc + operand;
      OP_SUB:  result_s = acc - operand;
      OP_AND:  result_s = acc & operand;
      OP_OR:   result_s = acc | operand;
      OP_NOT:  result_s = ~acc;
      OP_XOR:  result_s = acc ^ operand;
      OP_LOAD: result_s = operand;
      default: result_s = acc;
    endcase
  end

  assign result = result_s;

endmodule

// File: rtl/accumulator_cpu.sv
// Multicycle 16-bit accumulator CPU sharing one address bus between
// instruction fetch and data access to an external combinational memory.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   mem_in   - data word at address
//   instr_in - instruction word at address
//   address  - PC in FETCH, IR[11:0] in EXEC/STORE/HALT
//   write    - one-cycle store strobe, high only in STORE
//   mem_out  - store data, always the accumulator
// All outputs come straight from flops: address and write are precomputed from
// the next state so the bus is stable and the strobe glitch-free.
module accumulator_cpu
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] mem_out
);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [DATA_W-1:0] ir_r, ir_nxt_s;
  logic [DATA_W-1:0] acc_r, acc_nxt_s;
  logic [ADDR_W-1:0] address_r, address_nxt_s;
  logic              write_r;
  logic [DATA_W-1:0] alu_result_s;
  logic [OP_W-1:0]   opcode_s;

  assign opcode_s = ir_r[DATA_W-1:DATA_W-OP_W];

  cpu_alu u_alu (
    .opcode  (opcode_s),
    .acc     (acc_r),
    .operand (mem_in),
    .imm     (ir_r[ADDR_W-1:0]),
    .result  (alu_result_s)
  );

  // Next-state and datapath update logic for the fetch/execute/store FSM.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    acc_nxt_s   = acc_r;
    case (state_r)
      ST_FETCH: begin
        ir_nxt_s    = instr_in;
        pc_nxt_s    = pc_r + ADDR_W'(1);
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt_s = ST_FETCH;
        // PC already holds PC+1 from FETCH; a taken branch simply overwrites it.
        if (is_acc_op(opcode_s)) begin
          acc_nxt_s = alu_result_s;
        end else begin
          case (opcode_s)
            OP_STORE: state_nxt_s = ST_STORE;
            OP_JMP:   pc_nxt_s    = ir_r[ADDR_W-1:0];
            OP_JZ: begin
              if (acc_r == {DATA_W{1'b0}}) begin
                pc_nxt_s = ir_r[ADDR_W-1:0];
              end else begin
                pc_nxt_s = pc_r;
              end
            end
            OP_JN: begin
              if (acc_r[DATA_W-1] == 1'b1) begin
                pc_nxt_s = ir_r[ADDR_W-1:0];
              end else begin
                pc_nxt_s = pc_r;
              end
            end
            OP_HALT:  state_nxt_s = ST_HALT;
            default:  state_nxt_s = ST_FETCH;
          endcase
        end
      end
      ST_STORE: state_nxt_s = ST_FETCH;
      ST_HALT:  state_nxt_s = ST_HALT;
      default:  state_nxt_s = ST_FETCH;
    endcase

    if (state_nxt_s == ST_FETCH) begin
      address_nxt_s = pc_nxt_s;
    end else begin
      address_nxt_s = ir_nxt_s[ADDR_W-1:0];
    end
  end

  // State, datapath and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_FETCH;
      pc_r      <= RESET_PC;
      ir_r      <= {DATA_W{1'b0}};
      acc_r     <= {DATA_W{1'b0}};
      address_r <= RESET_PC;
      write_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      ir_r      <= ir_nxt_s;
      acc_r     <= acc_nxt_s;
      address_r <= address_nxt_s;
      write_r   <= (state_nxt_s == ST_STORE);
    end
  end

  assign address = address_r;
  assign write   = write_r;
  assign mem_out = acc_r;

endmodule

// File: tb/tb_accumulator_cpu.sv
module tb_accumulator_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] mem_in;
  logic [15:0] instr_in;
  logic [11:0] address;
  logic        write;
  logic [15:0] mem_out;

  logic [15:0] instr_mem [0:4095];
  logic [15:0] data_mem  [0:4095];
  logic [15:0] wr_mem    [0:4095];
  int          wcount;
  int          wbase;
  int          checks;
  int          fails;

  accumulator_cpu #(.RESET_PC(12'h000)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_in   (mem_in),
    .instr_in (instr_in),
    .address  (address),
    .write    (write),
    .mem_out  (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr_in = instr_mem[address];
  assign mem_in   = data_mem[address];

  initial wcount = 0;
  always @(posedge write) begin
    wr_mem[address] <= mem_out;
    wcount <= wcount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      instr_mem[i] = 16'h0000;
      data_mem[i]  = 16'h0000;
    end
  endtask

  // Hold reset for 3 cycles, check the reset outputs, release on a falling edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    step(3);
    #1;
    check({tag, " rst address"}, {20'd0, address}, 32'h000);
    check({tag, " rst write"}, {31'd0, write}, 32'h0);
    check({tag, " rst mem_out"}, {16'd0, mem_out}, 32'h0000);
    @(negedge clk);
    reset = 1'b1;
    wbase = wcount;
    #1;
    check({tag, " fetch addr0"}, {20'd0, address}, 32'h000);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    wbase  = 0;
    reset  = 1'b0;

    // Arithmetic: 10 + 15 - 6 = 19 stored at 32
    clear_mem();
    instr_mem[0] = 16'hA00A; instr_mem[1] = 16'h200F; instr_mem[2] = 16'h3003;
    instr_mem[3] = 16'h8020; instr_mem[4] = 16'hF000;
    data_mem[10] = 16'd10; data_mem[15] = 16'd15; data_mem[3] = 16'd6;
    do_reset("arith");
    step(1); #1;
    check("arith exec addr", {20'd0, address}, 32'h00A);
    check("arith ir fetched", {16'd0, instr_mem[0]}, 32'hA00A);
    step(6); #1;
    check("arith pre-store addr", {20'd0, address}, 32'h020);
    check("arith pre-store write", {31'd0, write}, 32'h0);
    check("arith data before strobe", {16'd0, mem_out}, 32'd19);
    step(1); #1;
    check("arith store write", {31'd0, write}, 32'h1);
    check("arith store addr", {20'd0, address}, 32'h020);
    check("arith store data", {16'd0, mem_out}, 32'd19);
    step(1); #1;
    check("arith write drop", {31'd0, write}, 32'h0);
    step(6); #1;
    check("arith halt addr", {20'd0, address}, 32'h000);
    check("arith halt write", {31'd0, write}, 32'h0);
    check("arith mem[32]", {16'd0, wr_mem[32]}, 32'd19);
    check("arith pulses", wcount - wbase, 32'd1);

    // Logic: 0x000F | 12 = 0x000F, NOT -> 0xFFF0 stored at 12
    clear_mem();
    instr_mem[0] = 16'h100F; instr_mem[1] = 16'h5002; instr_mem[2] = 16'h6000;
    instr_mem[3] = 16'h800C; instr_mem[4] = 16'hF000;
    data_mem[2] = 16'd12;
    do_reset("logic");
    step(16); #1;
    check("logic mem[12]", {16'd0, wr_mem[12]}, 32'hFFF0);
    check("logic pulses", wcount - wbase, 32'd1);
    check("logic acc", {16'd0, mem_out}, 32'hFFF0);

    // Branch: JZ taken skips the HALTs, store 5 at address 1
    clear_mem();
    instr_mem[0] = 16'h1000; instr_mem[1] = 16'hB004; instr_mem[2] = 16'hF000;
    instr_mem[3] = 16'hF000; instr_mem[4] = 16'h1005; instr_mem[5] = 16'h8001;
    instr_mem[6] = 16'hF000;
    do_reset("branch");
    step(4); #1;
    check("branch jz target fetch", {20'd0, address}, 32'h004);
    step(12); #1;
    check("branch mem[1]", {16'd0, wr_mem[1]}, 32'd5);
    check("branch pulses", wcount - wbase, 32'd1);
    check("branch halt addr", {20'd0, address}, 32'h000);

    // JN not taken with ACC=1, JMP 0xFFF, PC wraps to 0
    clear_mem();
    instr_mem[0] = 16'h1001; instr_mem[1] = 16'hC005; instr_mem[2] = 16'h9FFF;
    instr_mem[4095] = 16'h1007;
    do_reset("jn");
    step(1); #1; check("jn exec ldi", {20'd0, address}, 32'h001);
    step(1); #1; check("jn fetch1", {20'd0, address}, 32'h001);
    step(1); #1; check("jn exec jn", {20'd0, address}, 32'h005);
    step(1); #1; check("jn not taken", {20'd0, address}, 32'h002);
    step(1); #1; check("jn exec jmp", {20'd0, address}, 32'hFFF);
    step(1); #1; check("jmp target fetch", {20'd0, address}, 32'hFFF);
    step(1); #1; check("jmp exec ldi7", {20'd0, address}, 32'h007);
    step(1); #1; check("pc wrap", {20'd0, address}, 32'h000);
    check("jn acc", {16'd0, mem_out}, 32'h0007);

    // Reset asserted during STORE
    clear_mem();
    instr_mem[0] = 16'h1009; instr_mem[1] = 16'h8040; instr_mem[2] = 16'hF000;
    do_reset("abort");
    step(4); #1;
    check("abort store write", {31'd0, write}, 32'h1);
    check("abort store addr", {20'd0, address}, 32'h040);
    reset = 1'b0;
    #1;
    check("abort write drop", {31'd0, write}, 32'h0);
    check("abort address", {20'd0, address}, 32'h000);
    check("abort mem_out", {16'd0, mem_out}, 32'h0000);
    step(2);
    reset = 1'b1;
    #1;
    check("abort refetch addr", {20'd0, address}, 32'h000);
    step(1); #1;
    check("abort refetch exec", {20'd0, address}, 32'h009);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
